// File: rtl/accelerator_pkg.sv
// Shared types for the accelerator memory-side blocks: arbiter state, requester ids, OBI request payload.
package accelerator_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_VLSU = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    // Round-robin tie break: the requester that did not win last time.
    function automatic req_id_t rr_pick(input req_id_t last_grant);
        return (last_grant == REQ_CORE) ? REQ_VLSU : REQ_CORE;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of transaction owners; push and pop may occur in the same cycle.
module arb_owner_fifo
    import accelerator_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  req_id_t                  push_id,
    input  logic                     pop,
    output req_id_t                  head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_id_t            mem [DEPTH];
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               push_ok;
    logic               pop_ok;

    // Pointers wrap modulo DEPTH, which need not fill the pointer width.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head_id = mem[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr_q] <= push_id;
                wptr_q      <= ptr_inc(wptr_q);
            end
            if (pop_ok) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Shares one OBI data port between the core and the vector LSU; routes responses by in-order ownership.
module vector_mem_arbiter
    import accelerator_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      core_req_i,
    output logic                      core_gnt_o,
    output logic                      core_rvalid_o,
    input  logic [31:0]               core_addr_i,
    input  logic                      core_we_i,
    input  logic [3:0]                core_be_i,
    input  logic [31:0]               core_wdata_i,
    output logic [31:0]               core_rdata_o,
    input  logic                      vlsu_req_i,
    output logic                      vlsu_gnt_o,
    output logic                      vlsu_rvalid_o,
    input  logic [31:0]               vlsu_addr_i,
    input  logic                      vlsu_we_i,
    input  logic [3:0]                vlsu_be_i,
    input  logic [31:0]               vlsu_wdata_i,
    output logic [31:0]               vlsu_rdata_o,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    input  logic                      data_rvalid_i,
    output logic [31:0]               data_addr_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [31:0]               data_wdata_o,
    input  logic [31:0]               data_rdata_i,
    output logic [$clog2(MAX_OUTST):0] outst_cnt_o,
    output logic                      rsp_err_o
);

    arb_state_t state_q;
    req_id_t    sel_q;
    req_id_t    last_q;

    req_id_t    sel_c;
    logic       req_c;
    logic       grant_c;
    logic       pop_c;
    obi_req_t   core_r;
    obi_req_t   vlsu_r;
    obi_req_t   mux_r;

    req_id_t    head_id;
    logic       fifo_full;
    logic       fifo_empty;

    assign core_r = '{addr: core_addr_i, we: core_we_i, be: core_be_i, wdata: core_wdata_i};
    assign vlsu_r = '{addr: vlsu_addr_i, we: vlsu_we_i, be: vlsu_be_i, wdata: vlsu_wdata_i};

    // Selection: HOLD keeps the registered choice; IDLE arbitrates unless the owner FIFO is full.
    always_comb begin
        sel_c = REQ_CORE;
        req_c = 1'b0;
        if (state_q == ARB_HOLD) begin
            sel_c = sel_q;
            req_c = 1'b1;
        end else if (!fifo_full) begin
            if (core_req_i && vlsu_req_i) begin
                sel_c = rr_pick(last_q);
            end else if (vlsu_req_i) begin
                sel_c = REQ_VLSU;
            end
            req_c = core_req_i || vlsu_req_i;
        end
    end

    always_comb begin
        mux_r = '0;
        if (req_c) begin
            mux_r = (sel_c == REQ_CORE) ? core_r : vlsu_r;
        end
    end

    assign grant_c      = req_c && data_gnt_i;
    assign pop_c        = data_rvalid_i && !fifo_empty;

    assign data_req_o   = req_c;
    assign data_addr_o  = mux_r.addr;
    assign data_we_o    = mux_r.we;
    assign data_be_o    = mux_r.be;
    assign data_wdata_o = mux_r.wdata;

    assign core_gnt_o    = grant_c && (sel_c == REQ_CORE);
    assign vlsu_gnt_o    = grant_c && (sel_c == REQ_VLSU);
    assign core_rvalid_o = pop_c && (head_id == REQ_CORE);
    assign vlsu_rvalid_o = pop_c && (head_id == REQ_VLSU);
    assign core_rdata_o  = data_rdata_i;
    assign vlsu_rdata_o  = data_rdata_i;
    assign rsp_err_o     = data_rvalid_i && fifo_empty;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= ARB_IDLE;
            sel_q   <= REQ_CORE;
            last_q  <= REQ_VLSU;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (req_c && !data_gnt_i) begin
                        sel_q   <= sel_c;
                        state_q <= ARB_HOLD;
                    end
                end
                ARB_HOLD: begin
                    if (data_gnt_i) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
            if (grant_c) begin
                last_q <= sel_c;
            end
        end
    end

    arb_owner_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_owner_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (grant_c),
        .push_id (sel_c),
        .pop     (pop_c),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outst_cnt_o)
    );

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed bench for vector_mem_arbiter: arbitration, hold, backpressure, response routing, reset.
module tb_vector_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        core_req_i, core_we_i, vlsu_req_i, vlsu_we_i;
    logic [31:0] core_addr_i, core_wdata_i, vlsu_addr_i, vlsu_wdata_i;
    logic [3:0]  core_be_i, vlsu_be_i;
    logic        core_gnt_o, core_rvalid_o, vlsu_gnt_o, vlsu_rvalid_o;
    logic [31:0] core_rdata_o, vlsu_rdata_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic [1:0]  outst_cnt_o;
    logic        rsp_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vector_mem_arbiter #(.MAX_OUTST(2)) dut (
        .clk(clk), .n_reset(n_reset),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_addr_i(core_addr_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
        .vlsu_req_i(vlsu_req_i), .vlsu_gnt_o(vlsu_gnt_o), .vlsu_rvalid_o(vlsu_rvalid_o),
        .vlsu_addr_i(vlsu_addr_i), .vlsu_we_i(vlsu_we_i), .vlsu_be_i(vlsu_be_i),
        .vlsu_wdata_i(vlsu_wdata_i), .vlsu_rdata_o(vlsu_rdata_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
        .outst_cnt_o(outst_cnt_o), .rsp_err_o(rsp_err_o)
    );

    task automatic clear_inputs();
        core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0;
        vlsu_req_i = 0; vlsu_we_i = 0; vlsu_be_i = 0; vlsu_addr_i = 0; vlsu_wdata_i = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    endtask

    // Inputs change at negedge; the clock edge in between advances state.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_reset = 0;
        clear_inputs();
        step();
        n_reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if ({data_req_o, core_gnt_o, vlsu_gnt_o, core_rvalid_o, vlsu_rvalid_o, rsp_err_o} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 000000",
                {data_req_o, core_gnt_o, vlsu_gnt_o, core_rvalid_o, vlsu_rvalid_o, rsp_err_o}); end
        n_cmp++; if ({data_addr_o, data_wdata_o, data_be_o, data_we_o, outst_cnt_o} !== 71'b0) begin
            n_bad++; $display("FAIL reset_data: got addr=%h wdata=%h be=%h we=%b cnt=%0d want all 0",
                data_addr_o, data_wdata_o, data_be_o, data_we_o, outst_cnt_o); end
    endtask

    task automatic test_core_read();
        do_reset();
        core_req_i = 1; core_addr_i = 32'h0000_0100; core_be_i = 4'hF; data_gnt_i = 1;
        #1;
        n_cmp++; if ({core_gnt_o, vlsu_gnt_o} !== 2'b10) begin
            n_bad++; $display("FAIL rd_gnt: got core=%b vlsu=%b want 1 0", core_gnt_o, vlsu_gnt_o); end
        n_cmp++; if (data_addr_o !== 32'h0000_0100 || data_be_o !== 4'hF) begin
            n_bad++; $display("FAIL rd_addr: got %h/%h want 00000100/f", data_addr_o, data_be_o); end
        step();
        core_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b10 || core_rdata_o !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rd_rsp: got rv=%b%b rdata=%h want 10 deadbeef",
                core_rvalid_o, vlsu_rvalid_o, core_rdata_o); end
        n_cmp++; if (outst_cnt_o !== 2'd1) begin
            n_bad++; $display("FAIL rd_cnt1: got %0d want 1", outst_cnt_o); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (outst_cnt_o !== 2'd0 || vlsu_rvalid_o !== 1'b0) begin
            n_bad++; $display("FAIL rd_cnt0: got cnt=%0d vrv=%b want 0 0", outst_cnt_o, vlsu_rvalid_o); end
    endtask

    task automatic test_round_robin();
        logic exp_vlsu;
        do_reset();
        core_req_i = 1; vlsu_req_i = 1; data_gnt_i = 1;
        core_addr_i = 32'h0000_00A0; vlsu_addr_i = 32'h0000_00B0;
        for (int i = 0; i < 4; i++) begin
            exp_vlsu = (i % 2) == 1;
            data_rvalid_i = (i > 0);
            #1;
            n_cmp++; if ({core_gnt_o, vlsu_gnt_o} !== {!exp_vlsu, exp_vlsu}) begin
                n_bad++; $display("FAIL rr_gnt%0d: got core=%b vlsu=%b want %b %b",
                    i, core_gnt_o, vlsu_gnt_o, !exp_vlsu, exp_vlsu); end
            n_cmp++; if (data_addr_o !== (exp_vlsu ? 32'h0000_00B0 : 32'h0000_00A0)) begin
                n_bad++; $display("FAIL rr_addr%0d: got %h", i, data_addr_o); end
            if (i > 0) begin
                n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== {exp_vlsu, !exp_vlsu}) begin
                    n_bad++; $display("FAIL rr_rsp%0d: got rv=%b%b want %b%b",
                        i, core_rvalid_o, vlsu_rvalid_o, exp_vlsu, !exp_vlsu); end
            end
            step();
        end
        core_req_i = 0; vlsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
        #1;
        n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b01) begin
            n_bad++; $display("FAIL rr_drain: got rv=%b%b want 01", core_rvalid_o, vlsu_rvalid_o); end
        step();
        clear_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        vlsu_req_i = 1; vlsu_addr_i = 32'h0000_00B4; vlsu_we_i = 1; vlsu_wdata_i = 32'h1234_5678;
        core_addr_i = 32'h0000_00C4;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) core_req_i = 1;
            #1;
            n_cmp++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h0000_00B4 || core_gnt_o !== 1'b0) begin
                n_bad++; $display("FAIL hold%0d: got req=%b addr=%h cgnt=%b want 1 000000b4 0",
                    i, data_req_o, data_addr_o, core_gnt_o); end
            step();
        end
        data_gnt_i = 1;
        #1;
        n_cmp++; if ({core_gnt_o, vlsu_gnt_o} !== 2'b01 || data_addr_o !== 32'h0000_00B4
                     || data_wdata_o !== 32'h1234_5678 || data_we_o !== 1'b1) begin
            n_bad++; $display("FAIL hold_gnt: got gnt=%b%b addr=%h wdata=%h we=%b",
                core_gnt_o, vlsu_gnt_o, data_addr_o, data_wdata_o, data_we_o); end
        step();
        vlsu_req_i = 0;
        #1;
        n_cmp++; if ({core_gnt_o, vlsu_gnt_o} !== 2'b10 || data_addr_o !== 32'h0000_00C4 || data_we_o !== 1'b0) begin
            n_bad++; $display("FAIL hold_next: got gnt=%b%b addr=%h we=%b want 10 000000c4 0",
                core_gnt_o, vlsu_gnt_o, data_addr_o, data_we_o); end
        step();
        clear_inputs();
        data_rvalid_i = 1;
        #1;
        n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b01) begin
            n_bad++; $display("FAIL hold_rsp0: got %b%b want 01", core_rvalid_o, vlsu_rvalid_o); end
        step();
        #1;
        n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b10) begin
            n_bad++; $display("FAIL hold_rsp1: got %b%b want 10", core_rvalid_o, vlsu_rvalid_o); end
        step();
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        core_req_i = 1; data_gnt_i = 1; core_addr_i = 32'h0000_0200;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (core_gnt_o !== 1'b1) begin
                n_bad++; $display("FAIL full_gnt%0d: got %b want 1", i, core_gnt_o); end
            step();
        end
        data_rvalid_i = 1;
        #1;
        n_cmp++; if (data_req_o !== 1'b0 || core_gnt_o !== 1'b0 || outst_cnt_o !== 2'd2) begin
            n_bad++; $display("FAIL full_block: got req=%b gnt=%b cnt=%0d want 0 0 2",
                data_req_o, core_gnt_o, outst_cnt_o); end
        n_cmp++; if (core_rvalid_o !== 1'b1) begin
            n_bad++; $display("FAIL full_pop: got %b want 1", core_rvalid_o); end
        step();
        data_rvalid_i = 0;
        #1;
        n_cmp++; if (data_req_o !== 1'b1 || core_gnt_o !== 1'b1 || outst_cnt_o !== 2'd1) begin
            n_bad++; $display("FAIL full_resume: got req=%b gnt=%b cnt=%0d want 1 1 1",
                data_req_o, core_gnt_o, outst_cnt_o); end
        step();
        clear_inputs();
        data_rvalid_i = 1;
        step();
        step();
        data_rvalid_i = 0;
        #1;
        n_cmp++; if (outst_cnt_o !== 2'd0) begin
            n_bad++; $display("FAIL full_drain: got %0d want 0", outst_cnt_o); end
    endtask

    task automatic test_interleave();
        do_reset();
        core_req_i = 1; data_gnt_i = 1;
        step();
        core_req_i = 0; vlsu_req_i = 1;
        step();
        vlsu_req_i = 0; core_req_i = 1; data_rvalid_i = 1; data_rdata_i = 32'h1;
        #1;
        n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b10 || core_rdata_o !== 32'h1 || core_gnt_o !== 1'b0) begin
            n_bad++; $display("FAIL il_rsp1: got rv=%b%b rdata=%h gnt=%b want 10 1 0",
                core_rvalid_o, vlsu_rvalid_o, core_rdata_o, core_gnt_o); end
        step();
        data_rdata_i = 32'h2;
        #1;
        n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b01 || vlsu_rdata_o !== 32'h2 || core_gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL il_rsp2: got rv=%b%b rdata=%h gnt=%b want 01 2 1",
                core_rvalid_o, vlsu_rvalid_o, vlsu_rdata_o, core_gnt_o); end
        step();
        core_req_i = 0; data_gnt_i = 0; data_rdata_i = 32'h3;
        #1;
        n_cmp++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b10 || core_rdata_o !== 32'h3) begin
            n_bad++; $display("FAIL il_rsp3: got rv=%b%b rdata=%h want 10 3",
                core_rvalid_o, vlsu_rvalid_o, core_rdata_o); end
        step();
        clear_inputs();
    endtask

    task automatic test_errors_and_reset();
        do_reset();
        data_rvalid_i = 1;
        #1;
        n_cmp++; if (rsp_err_o !== 1'b1 || {core_rvalid_o, vlsu_rvalid_o} !== 2'b00) begin
            n_bad++; $display("FAIL err_pulse: got err=%b rv=%b%b want 1 00", rsp_err_o, core_rvalid_o, vlsu_rvalid_o); end
        step();
        data_rvalid_i = 0;
        #1;
        n_cmp++; if (rsp_err_o !== 1'b0 || outst_cnt_o !== 2'd0) begin
            n_bad++; $display("FAIL err_clear: got err=%b cnt=%0d want 0 0", rsp_err_o, outst_cnt_o); end
        core_req_i = 1; data_gnt_i = 1;
        step();
        core_req_i = 0; data_gnt_i = 0; vlsu_req_i = 1;
        step();
        vlsu_req_i = 0;
        #1;
        n_cmp++; if (data_req_o !== 1'b1 || outst_cnt_o !== 2'd1) begin
            n_bad++; $display("FAIL rst_pre: got req=%b cnt=%0d want 1 1", data_req_o, outst_cnt_o); end
        n_reset = 0;
        step();
        n_reset = 1;
        #1;
        n_cmp++; if (data_req_o !== 1'b0 || outst_cnt_o !== 2'd0) begin
            n_bad++; $display("FAIL rst_hold: got req=%b cnt=%0d want 0 0", data_req_o, outst_cnt_o); end
        data_rvalid_i = 1;
        #1;
        n_cmp++; if (rsp_err_o !== 1'b1 || core_rvalid_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_late_rsp: got err=%b crv=%b want 1 0", rsp_err_o, core_rvalid_o); end
        step();
        data_rvalid_i = 0; core_req_i = 1; vlsu_req_i = 1; data_gnt_i = 1;
        #1;
        n_cmp++; if ({core_gnt_o, vlsu_gnt_o} !== 2'b10) begin
            n_bad++; $display("FAIL rst_rr: got %b%b want 10", core_gnt_o, vlsu_gnt_o); end
        step();
        clear_inputs();
    endtask

    initial begin
        n_reset = 0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_core_read();
        test_round_robin();
        test_hold();
        test_full();
        test_interleave();
        test_errors_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion want finish by 100000");
        $fatal(1);
    end

endmodule
